// File: rtl/oak8m_mem_ctrl_if.sv
// Bus bundle between the oak8m core, the memory controller and the external Wishbone SRAM.
// The controller takes the slave view; the core plus SRAM environment take the master view.
interface oak8m_mem_ctrl_if;
    logic        select;
    logic [7:0]  addr;
    logic [7:0]  data_in;
    logic        memory_type_data;
    logic        write;
    logic [7:0]  data_out;
    logic        data_ready;
    logic        bus_error;

    logic        sram_stb_o;
    logic        sram_cyc_o;
    logic        sram_we_o;
    logic [3:0]  sram_sel_o;
    logic [31:0] sram_dat_o;
    logic [9:0]  sram_addr_o;
    logic        sram_ack_i;
    logic [31:0] sram_dat_i;

    modport master (
        output select, addr, data_in, memory_type_data, write, sram_ack_i, sram_dat_i,
        input  data_out, data_ready, bus_error,
               sram_stb_o, sram_cyc_o, sram_we_o, sram_sel_o, sram_dat_o, sram_addr_o
    );

    modport slave (
        input  select, addr, data_in, memory_type_data, write, sram_ack_i, sram_dat_i,
        output data_out, data_ready, bus_error,
               sram_stb_o, sram_cyc_o, sram_we_o, sram_sel_o, sram_dat_o, sram_addr_o
    );
endinterface

// File: rtl/oak8m_mem_ctrl.sv
// oak8m memory/IO controller: routes core accesses to code RAM, Wishbone SRAM,
// data RAM or GPIO registers, and aborts SRAM accesses that are never acked.
module oak8m_mem_ctrl #(
    parameter int unsigned CODE_DEPTH = 32,
    parameter int unsigned DATA_DEPTH = 32,
    parameter int unsigned WB_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sram_enable,
    input  logic [7:0]      io_in,
    output logic [7:0]      io_out,
    output logic [7:0]      io_oeb,
    oak8m_mem_ctrl_if.slave bus
);
    localparam int unsigned CODE_AW = (CODE_DEPTH > 1) ? $clog2(CODE_DEPTH) : 1;
    localparam int unsigned DATA_AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int unsigned TO_W    = 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(WB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INT, S_EXT, S_DONE, S_RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        req_addr_q, req_addr_d;
    logic [7:0]        req_wdata_q, req_wdata_d;
    logic              req_write_q, req_write_d;
    logic              req_data_q, req_data_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              data_ready_q, data_ready_d;
    logic              bus_error_q, bus_error_d;
    logic [7:0]        io_out_q, io_out_d;
    logic [7:0]        io_oeb_q, io_oeb_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [9:0]        waddr_q, waddr_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              code_we, data_we;

    logic [7:0]         code_mem [CODE_DEPTH];
    logic [7:0]         data_mem [DATA_DEPTH];
    logic [CODE_AW-1:0] code_idx;
    logic [DATA_AW-1:0] data_idx;

    assign code_idx = req_addr_q[CODE_AW-1:0];
    assign data_idx = req_addr_q[DATA_AW-1:0];

    // Next-state and next-output logic; every register keeps its value unless a state says otherwise.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_write_d  = req_write_q;
        req_data_d   = req_data_q;
        data_out_d   = data_out_q;
        data_ready_d = 1'b0;
        bus_error_d  = 1'b0;
        io_out_d     = io_out_q;
        io_oeb_d     = io_oeb_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        sel_d        = sel_q;
        wdat_d       = wdat_q;
        waddr_d      = waddr_q;
        to_cnt_d     = to_cnt_q;
        code_we      = 1'b0;
        data_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (bus.select) begin
                    req_addr_d  = bus.addr;
                    req_wdata_d = bus.data_in;
                    req_write_d = bus.write;
                    req_data_d  = bus.memory_type_data;
                    state_d     = (!bus.memory_type_data && sram_enable) ? S_EXT : S_INT;
                end
            end

            S_INT: begin
                state_d      = S_DONE;
                data_ready_d = 1'b1;
                if (!req_data_q) begin
                    if (req_write_q) code_we = 1'b1;
                    else             data_out_d = code_mem[code_idx];
                end else if (req_addr_q < 8'(DATA_DEPTH)) begin
                    if (req_write_q) data_we = 1'b1;
                    else             data_out_d = data_mem[data_idx];
                end else begin
                    case (req_addr_q)
                        8'hF0: if (!req_write_q) data_out_d = io_in;
                        8'hF1: if (req_write_q) io_out_d = req_wdata_q; else data_out_d = io_out_q;
                        8'hF2: if (req_write_q) io_oeb_d = req_wdata_q; else data_out_d = io_oeb_q;
                        default: if (!req_write_q) data_out_d = 8'h00;
                    endcase
                end
            end

            // Bus signals are registered, so strobe rises one cycle into EXT; ack beats timeout.
            S_EXT: begin
                if (bus.sram_ack_i) begin
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    we_d         = 1'b0;
                    sel_d        = 4'b0000;
                    if (!req_write_q) data_out_d = bus.sram_dat_i[{req_addr_q[1:0], 3'b000} +: 8];
                    state_d      = S_DONE;
                    data_ready_d = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    we_d         = 1'b0;
                    sel_d        = 4'b0000;
                    to_cnt_d     = TO_W'(WB_TIMEOUT);
                    data_out_d   = 8'hFF;
                    bus_error_d  = 1'b1;
                    state_d      = S_DONE;
                    data_ready_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    we_d     = req_write_q;
                    sel_d    = 4'b0001 << req_addr_q[1:0];
                    wdat_d   = {4{req_wdata_q}};
                    waddr_d  = {4'b0000, req_addr_q[7:2]};
                end
            end

            S_DONE: state_d = S_RELEASE;

            // A select still held from the finished access is not a new request.
            S_RELEASE: if (!bus.select) state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_write_q  <= 1'b0;
            req_data_q   <= 1'b0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            bus_error_q  <= 1'b0;
            io_out_q     <= 8'h00;
            io_oeb_q     <= 8'hFF;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            wdat_q       <= '0;
            waddr_q      <= '0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_write_q  <= req_write_d;
            req_data_q   <= req_data_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
            bus_error_q  <= bus_error_d;
            io_out_q     <= io_out_d;
            io_oeb_q     <= io_oeb_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            wdat_q       <= wdat_d;
            waddr_q      <= waddr_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    // RAM arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (code_we) code_mem[code_idx] <= req_wdata_q;
        if (data_we) data_mem[data_idx] <= req_wdata_q;
    end

    assign bus.data_out    = data_out_q;
    assign bus.data_ready  = data_ready_q;
    assign bus.bus_error   = bus_error_q;
    assign bus.sram_cyc_o  = cyc_q;
    assign bus.sram_stb_o  = stb_q;
    assign bus.sram_we_o   = we_q;
    assign bus.sram_sel_o  = sel_q;
    assign bus.sram_dat_o  = wdat_q;
    assign bus.sram_addr_o = waddr_q;
    assign io_out          = io_out_q;
    assign io_oeb          = io_oeb_q;
endmodule

// File: tb/tb_oak8m_mem_ctrl.sv
// Randomized bench for oak8m_mem_ctrl against a byte-level memory map model and a Wishbone SRAM slave.
module tb_oak8m_mem_ctrl;
    localparam int unsigned CODE_DEPTH = 32;
    localparam int unsigned DATA_DEPTH = 32;
    localparam int unsigned WB_TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic       sram_enable;
    logic [7:0] io_in;
    logic [7:0] io_out;
    logic [7:0] io_oeb;

    oak8m_mem_ctrl_if bus();

    oak8m_mem_ctrl #(
        .CODE_DEPTH(CODE_DEPTH),
        .DATA_DEPTH(DATA_DEPTH),
        .WB_TIMEOUT(WB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sram_enable(sram_enable),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference memory map: byte arrays for every target plus the SRAM word store seen by the slave.
    logic [7:0]  code_m [CODE_DEPTH];
    logic [7:0]  data_m [DATA_DEPTH];
    logic [7:0]  ext_m  [256];
    logic [31:0] sram_w [64];
    logic [7:0]  io_out_m, io_oeb_m, dout_m, io_pat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_sram_word(input int idx, input logic [31:0] w);
        sram_w[idx] = w;
        for (int l = 0; l < 4; l++) ext_m[idx*4 + l] = w[8*l +: 8];
    endtask

    task automatic model_reset();
        dout_m   = 8'h00;
        io_out_m = 8'h00;
        io_oeb_m = 8'hFF;
    endtask

    function automatic logic [7:0] int_read(input bit md, input logic [7:0] a);
        if (!md)                return code_m[int'(a) % CODE_DEPTH];
        if (int'(a) < DATA_DEPTH) return data_m[a];
        if (a == 8'hF0)         return io_pat;
        if (a == 8'hF1)         return io_out_m;
        if (a == 8'hF2)         return io_oeb_m;
        return 8'h00;
    endfunction

    task automatic int_write(input bit md, input logic [7:0] a, input logic [7:0] wd);
        if (!md)                       code_m[int'(a) % CODE_DEPTH] = wd;
        else if (int'(a) < DATA_DEPTH) data_m[a] = wd;
        else if (a == 8'hF1)           io_out_m = wd;
        else if (a == 8'hF2)           io_oeb_m = wd;
    endtask

    // One full access: ack_after = strobe cycles before the slave acks (-1 = never), hold = extra select-high cycles.
    task automatic run_access(input bit sen, input bit md, input bit wr, input logic [7:0] a,
                              input logic [7:0] wd, input int ack_after, input int hold);
        bit         ext, acked_m, exp_err, exp_stb, slave_done;
        int         exp_lat, stb_cnt, widx, ack_n;
        logic [7:0] exp_do;
        logic [3:0] exp_sel;

        ack_n   = ack_after;
        ext     = !md && sen;
        if (ext && wr && ack_n == 0) ack_n = 1;
        acked_m = ext && ack_n >= 0 && ack_n + 1 <= int'(WB_TIMEOUT);
        exp_err = ext && !acked_m;
        if (!ext)         exp_lat = 2;
        else if (acked_m) exp_lat = 2 + ack_n;
        else              exp_lat = int'(WB_TIMEOUT) + 1;
        exp_sel = 4'(1 << a[1:0]);

        exp_do = dout_m;
        if (!ext) begin
            if (wr) int_write(md, a, wd);
            else    exp_do = int_read(md, a);
        end else if (exp_err) exp_do = 8'hFF;
        else if (wr)          ext_m[a] = wd;
        else                  exp_do = ext_m[a];
        dout_m = exp_do;

        @(posedge clk); #1;
        io_in                = io_pat;
        bus.select           = 1'b1;
        sram_enable          = sen;
        bus.memory_type_data = md;
        bus.write            = wr;
        bus.addr             = a;
        bus.data_in          = wd;
        bus.sram_ack_i       = 1'b0;
        stb_cnt              = 0;
        slave_done           = 1'b0;

        for (int t = 1; t <= exp_lat + hold + 2; t++) begin
            @(posedge clk); #1;
            sram_enable          = 1'($urandom);
            bus.memory_type_data = 1'($urandom);
            bus.write            = 1'($urandom);
            bus.addr             = 8'($urandom);
            bus.data_in          = 8'($urandom);
            if (t > exp_lat + hold) bus.select = 1'b0;

            bus.sram_ack_i = 1'b0;
            bus.sram_dat_i = $urandom;
            if (ext && ack_n >= 0 && !slave_done) begin
                if (bus.sram_stb_o) stb_cnt++;
                if (stb_cnt == ack_n) begin
                    widx = bus.sram_stb_o ? int'(bus.sram_addr_o[5:0]) : int'(a[7:2]);
                    if (bus.sram_stb_o && bus.sram_we_o)
                        for (int l = 0; l < 4; l++)
                            if (bus.sram_sel_o[l]) sram_w[widx][8*l +: 8] = bus.sram_dat_o[8*l +: 8];
                    bus.sram_dat_i = sram_w[widx];
                    bus.sram_ack_i = 1'b1;
                    slave_done     = 1'b1;
                end
            end

            @(negedge clk);
            exp_stb = ext && t >= 2 && t < exp_lat;
            chk("wb_cyc_stb_we", {bus.sram_cyc_o, bus.sram_stb_o, bus.sram_we_o},
                exp_stb ? {2'b11, wr} : 3'b000);
            chk("wb_sel", bus.sram_sel_o, exp_stb ? exp_sel : 4'h0);
            if (exp_stb)
                chk("wb_addr_dat", {bus.sram_addr_o, bus.sram_dat_o}, {10'(a >> 2), {4{wd}}});
            chk("data_ready", bus.data_ready, t == exp_lat);
            chk("bus_error", bus.bus_error, t == exp_lat && exp_err);
            if (t == exp_lat) chk("data_out", bus.data_out, exp_do);
        end
        chk("io_out", io_out, io_out_m);
        chk("io_oeb", io_oeb, io_oeb_m);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, aa, hold;
        bit md, wr, sen;
        logic [7:0] a;

        reset = 1'b0; sram_enable = 1'b0; io_in = 8'h00; io_pat = 8'h00;
        bus.select = 1'b0; bus.addr = 8'h00; bus.data_in = 8'h00;
        bus.memory_type_data = 1'b0; bus.write = 1'b0;
        bus.sram_ack_i = 1'b0; bus.sram_dat_i = 32'h0;
        for (int i = 0; i < 64; i++) set_sram_word(i, $urandom);
        model_reset();

        #12;
        chk("rst_io_oeb", io_oeb, 8'hFF);
        chk("rst_io_out", io_out, 8'h00);
        chk("rst_wb", {bus.sram_cyc_o, bus.sram_stb_o, bus.sram_we_o, bus.sram_sel_o,
                       bus.sram_dat_o, bus.sram_addr_o}, 49'h0);
        chk("rst_ready_err", {bus.data_ready, bus.bus_error}, 2'b00);
        chk("rst_data_out", bus.data_out, 8'h00);
        @(posedge clk); #1 reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_no_ready", bus.data_ready, 1'b0);
        end

        for (int i = 0; i < int'(CODE_DEPTH); i++) run_access(1'b0, 1'b0, 1'b1, 8'(i), 8'($urandom), 0, 0);
        for (int i = 0; i < int'(DATA_DEPTH); i++) run_access(1'b1, 1'b1, 1'b1, 8'(i), 8'($urandom), 0, 0);

        run_access(1'b0, 1'b0, 1'b1, 8'h05, 8'hA7, 0, 0);
        run_access(1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 0, 1);
        run_access(1'b0, 1'b0, 1'b0, 8'h25, 8'h00, 0, 0);
        chk("code_alias", bus.data_out, 8'hA7);

        run_access(1'b0, 1'b1, 1'b1, 8'hF2, 8'h0F, 0, 0);
        run_access(1'b0, 1'b1, 1'b1, 8'hF1, 8'h5A, 0, 0);
        chk("gpio_oeb", io_oeb, 8'h0F);
        chk("gpio_out", io_out, 8'h5A);
        io_pat = 8'hC3;
        run_access(1'b0, 1'b1, 1'b0, 8'hF0, 8'h00, 0, 0);
        chk("gpio_in", bus.data_out, 8'hC3);
        run_access(1'b0, 1'b1, 1'b0, 8'h80, 8'h00, 0, 0);
        chk("unmapped_rd", bus.data_out, 8'h00);

        set_sram_word(3, 32'h44332211);
        run_access(1'b1, 1'b0, 1'b0, 8'h0E, 8'h00, 3, 0);
        chk("sram_rd_lane2", bus.data_out, 8'h33);
        run_access(1'b1, 1'b0, 1'b1, 8'h0D, 8'h99, 2, 0);
        run_access(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, -1, 0);
        chk("timeout_ff", bus.data_out, 8'hFF);
        run_access(1'b1, 1'b0, 1'b0, 8'h0D, 8'h00, int'(WB_TIMEOUT) - 1, 0);
        chk("ack_at_timeout", bus.data_out, 8'h99);
        run_access(1'b1, 1'b0, 1'b0, 8'h0E, 8'h00, 0, 2);

        // Reset while the strobe is up: bus drops without waiting for a clock, access is lost.
        @(posedge clk); #1;
        bus.select = 1'b1; sram_enable = 1'b1; bus.memory_type_data = 1'b0;
        bus.write = 1'b0; bus.addr = 8'h10; bus.sram_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_cyc_stb", {bus.sram_cyc_o, bus.sram_stb_o}, 2'b11);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_cyc_stb", {bus.sram_cyc_o, bus.sram_stb_o}, 2'b00);
        chk("rst_async_ready", bus.data_ready, 1'b0);
        bus.select = 1'b0;
        model_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_stale_ready", bus.data_ready, 1'b0);
        end
        run_access(1'b0, 1'b1, 1'b0, 8'h03, 8'h00, 0, 0);
        run_access(1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 0, 0);
        chk("ram_survives_rst", bus.data_out, 8'hA7);

        for (int n = 0; n < 200; n++) begin
            md  = 1'($urandom);
            wr  = 1'($urandom);
            sen = 1'($urandom);
            r   = $urandom_range(0, 9);
            if (md) begin
                case (r)
                    6:       a = 8'hF0;
                    7:       a = 8'hF1;
                    8:       a = 8'hF2;
                    9:       a = 8'($urandom);
                    default: a = 8'($urandom_range(0, DATA_DEPTH - 1));
                endcase
            end else a = 8'($urandom);
            aa     = ($urandom_range(0, 59) == 0) ? -1 : $urandom_range(0, 4);
            hold   = $urandom_range(0, 3);
            io_pat = 8'($urandom);
            run_access(sen, md, wr, a, 8'($urandom), aa, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
